// File: rtl/spi_ram_pkg.sv
// Shared state encoding and opcodes for the SPI burst RAM slave.
package spi_ram_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    WR_ADDR = 3'd2,
    WR_DATA = 3'd3,
    RD_ADDR = 3'd4,
    RD_DATA = 3'd5,
    DRAIN   = 3'd6
  } state_e;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

endpackage

// File: rtl/spr_ram.sv
// Single-port RAM with a registered read port (one cycle latency).
module spr_ram #(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned ADDR_SIZE = 8,
  parameter int unsigned DATA_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic                 re,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [DATA_SIZE-1:0] din,
  output logic [DATA_SIZE-1:0] dout
);

  logic [DATA_SIZE-1:0] MEM [MEM_DEPTH];

  // Write has priority; read data holds until the next read.
  always_ff @(posedge clk) begin
    if (we) begin
      MEM[addr] <= din;
    end else if (re) begin
      dout <= MEM[addr];
    end
  end

endmodule

// File: rtl/spi_ram_burst_slave.sv
// SPI slave front-end with burst read/write into an on-chip RAM.
// Assumes max(ADDR_SIZE, DATA_SIZE) >= 2 so the opcode fits the input shifter.
module spi_ram_burst_slave
  import spi_ram_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned ADDR_SIZE = 8,
  parameter int unsigned DATA_SIZE = 8,
  parameter bit          AUTO_INC  = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO
);

  localparam int unsigned SH_W  = (ADDR_SIZE > DATA_SIZE) ? ADDR_SIZE : DATA_SIZE;
  localparam int unsigned CNT_W = $clog2(SH_W + 1);
  localparam logic [CNT_W-1:0]   CNT_ADDR = CNT_W'(ADDR_SIZE);
  localparam logic [CNT_W-1:0]   CNT_DATA = CNT_W'(DATA_SIZE);
  localparam logic [ADDR_SIZE:0] DEPTH_X  = (ADDR_SIZE + 1)'(MEM_DEPTH);
  localparam logic [ADDR_SIZE:0] LAST_X   = (ADDR_SIZE + 1)'(MEM_DEPTH - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
  logic [SH_W-1:0]      sin_q, sin_d, sin_next;
  logic [DATA_SIZE-1:0] sout_q, sout_d;
  logic                 miso_q, miso_d;
  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
  logic                 ss_hi_q, ss_hi_d;

  logic                 ram_we_c, ram_re_c;
  logic [ADDR_SIZE-1:0] ram_addr_c;
  logic [DATA_SIZE-1:0] ram_wdata_c, ram_rdata;

  // Out-of-range pointers are used as address 0.
  function automatic logic [ADDR_SIZE-1:0] clamp(input logic [ADDR_SIZE-1:0] a);
    return ({1'b0, a} >= DEPTH_X) ? '0 : a;
  endfunction

  // Next pointer after an access, wrapping past the last word.
  function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
    logic [ADDR_SIZE-1:0] e;
    e = clamp(a);
    return ({1'b0, e} == LAST_X) ? '0 : e + ADDR_SIZE'(1);
  endfunction

  // Frame decode, shifters and pointer update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sin_d       = sin_q;
    sout_d      = sout_q;
    miso_d      = 1'b0;
    wr_addr_d   = wr_addr_q;
    rd_addr_d   = rd_addr_q;
    ss_hi_d     = SS_n;
    ram_we_c    = 1'b0;
    ram_re_c    = 1'b0;
    ram_addr_c  = '0;
    sin_next    = (sin_q << 1) | SH_W'(MOSI);
    cnt_inc     = cnt_q + CNT_W'(1);
    ram_wdata_c = sin_next[DATA_SIZE-1:0];

    case (state_q)
      IDLE: begin
        // A new frame needs SS_n seen high at least once since the last one.
        if (!SS_n && ss_hi_q) begin
          state_d = CMD;
          cnt_d   = '0;
          sin_d   = '0;
        end
      end
      CMD: begin
        sin_d = sin_next;
        cnt_d = cnt_inc;
        if (cnt_q == CNT_W'(1)) begin
          cnt_d = '0;
          sin_d = '0;
          case (sin_next[1:0])
            OP_WR_ADDR: state_d = WR_ADDR;
            OP_WR_DATA: state_d = WR_DATA;
            OP_RD_ADDR: state_d = RD_ADDR;
            OP_RD_DATA: state_d = RD_DATA;
          endcase
        end
      end
      WR_ADDR, RD_ADDR: begin
        sin_d = sin_next;
        cnt_d = cnt_inc;
        if (cnt_inc == CNT_ADDR) begin
          if (state_q == WR_ADDR) wr_addr_d = sin_next[ADDR_SIZE-1:0];
          else                    rd_addr_d = sin_next[ADDR_SIZE-1:0];
          state_d = DRAIN;
        end
      end
      WR_DATA: begin
        sin_d = sin_next;
        cnt_d = cnt_inc;
        if (cnt_inc == CNT_DATA) begin
          ram_we_c  = 1'b1;
          wr_addr_d = next_addr(wr_addr_q);
          cnt_d     = '0;
          sin_d     = '0;
          if (!AUTO_INC) state_d = DRAIN;
        end
      end
      RD_DATA: begin
        // cnt 0: first read in flight; cnt DATA_SIZE: word ready to load.
        if (cnt_q == '0) begin
          ram_re_c = 1'b1;
          cnt_d    = CNT_DATA;
        end else begin
          if (cnt_q == CNT_DATA) begin
            sout_d    = ram_rdata;
            cnt_d     = CNT_W'(1);
            rd_addr_d = next_addr(rd_addr_q);
          end else begin
            sout_d = sout_q << 1;
            cnt_d  = cnt_inc;
          end
          miso_d = sout_d[DATA_SIZE-1];
          // Last bit of the word is now on MISO: prefetch or stop.
          if (cnt_d == CNT_DATA) begin
            if (AUTO_INC) ram_re_c = 1'b1;
            else          state_d  = DRAIN;
          end
        end
      end
      DRAIN: ;
      default: state_d = IDLE;
    endcase

    // Deselect discards any partial word and ends the frame.
    if (SS_n) begin
      state_d   = IDLE;
      miso_d    = 1'b0;
      cnt_d     = '0;
      sin_d     = '0;
      wr_addr_d = wr_addr_q;
      rd_addr_d = rd_addr_q;
      ram_we_c  = 1'b0;
      ram_re_c  = 1'b0;
    end

    ram_addr_c = clamp(ram_we_c ? wr_addr_q : rd_addr_q);
  end

  // State, shifters, pointers and MISO register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sin_q     <= '0;
      sout_q    <= '0;
      miso_q    <= 1'b0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      ss_hi_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sin_q     <= sin_d;
      sout_q    <= sout_d;
      miso_q    <= miso_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      ss_hi_q   <= ss_hi_d;
    end
  end

  assign MISO = miso_q;

  spr_ram #(
    .MEM_DEPTH(MEM_DEPTH),
    .ADDR_SIZE(ADDR_SIZE),
    .DATA_SIZE(DATA_SIZE)
  ) RAM (
    .clk (clk),
    .we  (ram_we_c),
    .re  (ram_re_c),
    .addr(ram_addr_c),
    .din (ram_wdata_c),
    .dout(ram_rdata)
  );

endmodule

// File: tb/tb_spi_ram_burst_slave.sv
// Scoreboard bench: two configurations (256x8 burst, 200x16 single-word).
module tb_spi_ram_burst_slave;
  import spi_ram_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  logic ss_n0, mosi0, miso0;
  logic ss_n1, mosi1, miso1;

  always #5 clk = ~clk;

  spi_ram_burst_slave #(.MEM_DEPTH(256), .ADDR_SIZE(8), .DATA_SIZE(8), .AUTO_INC(1'b1)) dut0 (
    .clk(clk), .rstn(rstn), .SS_n(ss_n0), .MOSI(mosi0), .MISO(miso0));

  spi_ram_burst_slave #(.MEM_DEPTH(200), .ADDR_SIZE(8), .DATA_SIZE(16), .AUTO_INC(1'b0)) dut1 (
    .clk(clk), .rstn(rstn), .SS_n(ss_n1), .MOSI(mosi1), .MISO(miso1));

  typedef struct {
    int    dut;
    int    cyc;
    logic  bitv;
    string tag;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  // Rising-edge counter used as the time key for expected MISO bits.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare MISO against every expectation due at this cycle.
  initial begin
    exp_t e;
    logic act;
    forever begin
      @(negedge clk);
      while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        e   = sbq.pop_front();
        act = (e.dut == 0) ? miso0 : miso1;
        checks++;
        if (e.cyc != cyc || act !== e.bitv) begin
          failures++;
          $display("FAIL %s dut%0d: MISO=%b at cyc %0d, required %b at cyc %0d",
                   e.tag, e.dut, act, cyc, e.bitv, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input int d, input int c, input logic b, input string tag);
    exp_t e;
    e.dut = d; e.cyc = c; e.bitv = b; e.tag = tag;
    sbq.push_back(e);
  endtask

  task automatic set_pins(input int d, input logic s, input logic m);
    if (d == 0) begin ss_n0 = s; mosi0 = m; end
    else        begin ss_n1 = s; mosi1 = m; end
  endtask

  // One frame; entered and left just after a falling edge.
  task automatic frame(input int d, input logic [1:0] op, input logic [63:0] pl, input int n);
    set_pins(d, 1'b0, 1'b0);
    @(negedge clk); set_pins(d, 1'b0, op[1]);
    @(negedge clk); set_pins(d, 1'b0, op[0]);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk); set_pins(d, 1'b0, pl[i]);
    end
    @(negedge clk); set_pins(d, 1'b1, 1'b0);
    @(negedge clk);
  endtask

  // Read frame of nw words: schedules every expected MISO bit, then runs it.
  task automatic rd_frame(input int d, input int dw, input int nw, input bit ai,
                          input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
    logic [15:0] w [3];
    int p, n;
    w[0] = w0; w[1] = w1; w[2] = w2;
    p = cyc + 1;
    n = ai ? nw * dw + 1 : dw + 2;
    push_exp(d, p + 3, 1'b0, "pre_load");
    for (int k = 0; k < nw; k++)
      for (int i = dw - 1; i >= 0; i--)
        push_exp(d, p + 4 + k * dw + (dw - 1 - i), w[k][i], $sformatf("rd_w%0d_b%0d", k, i));
    if (!ai) push_exp(d, p + 4 + dw, 1'b0, "drain_zero");
    push_exp(d, p + 3 + n, 1'b0, "deselect_zero");
    frame(d, OP_RD_DATA, 64'h0, n);
  endtask

  initial begin
    int p;
    rstn = 1'b0;
    set_pins(0, 1'b1, 1'b0);
    set_pins(1, 1'b1, 1'b0);

    // Reset and idle
    repeat (20) @(negedge clk);
    rstn = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      push_exp(0, cyc + k, 1'b0, "idle");
      push_exp(1, cyc + k, 1'b0, "idle");
    end
    repeat (10) @(negedge clk);
    chk("rst_wr_addr0", int'(dut0.wr_addr_q), 0);
    chk("rst_rd_addr0", int'(dut0.rd_addr_q), 0);
    chk("rst_state0", int'(dut0.state_q), int'(IDLE));
    chk("rst_rd_addr1", int'(dut1.rd_addr_q), 0);

    // Single write/read
    frame(0, OP_WR_ADDR, 64'h7E, 8);
    chk("wr_addr_load", int'(dut0.wr_addr_q), 'h7E);
    frame(0, OP_WR_DATA, 64'hA5, 8);
    chk("mem_7e", int'(dut0.RAM.MEM[8'h7E]), 'hA5);
    chk("wr_addr_inc", int'(dut0.wr_addr_q), 'h7F);
    frame(0, OP_RD_ADDR, 64'h7E, 8);
    chk("rd_addr_load", int'(dut0.rd_addr_q), 'h7E);
    rd_frame(0, 8, 1, 1'b1, 16'hA5, 16'h0, 16'h0);
    chk("rd_addr_inc", int'(dut0.rd_addr_q), 'h7F);

    // Burst write and read across the wrap
    frame(0, OP_WR_ADDR, 64'hFE, 8);
    frame(0, OP_WR_DATA, 64'h112233, 24);
    chk("mem_fe", int'(dut0.RAM.MEM[8'hFE]), 'h11);
    chk("mem_ff", int'(dut0.RAM.MEM[8'hFF]), 'h22);
    chk("mem_00", int'(dut0.RAM.MEM[8'h00]), 'h33);
    chk("wr_addr_wrap", int'(dut0.wr_addr_q), 'h01);
    frame(0, OP_RD_ADDR, 64'hFE, 8);
    rd_frame(0, 8, 3, 1'b1, 16'h11, 16'h22, 16'h33);
    chk("rd_addr_wrap", int'(dut0.rd_addr_q), 'h01);

    // Aborted partial word
    frame(0, OP_WR_ADDR, 64'h40, 8);
    frame(0, OP_WR_DATA, 64'h5C, 8);
    frame(0, OP_WR_ADDR, 64'h40, 8);
    frame(0, OP_WR_DATA, 64'h15, 5);
    chk("abort_mem", int'(dut0.RAM.MEM[8'h40]), 'h5C);
    chk("abort_wr_addr", int'(dut0.wr_addr_q), 'h40);
    frame(0, OP_RD_ADDR, 64'h40, 8);
    rd_frame(0, 8, 1, 1'b1, 16'h5C, 16'h0, 16'h0);

    // Single-word mode, depth 200, 16-bit words
    frame(1, OP_WR_ADDR, 64'h06, 8);
    frame(1, OP_WR_DATA, 64'h1234, 16);
    chk("d1_mem6_init", int'(dut1.RAM.MEM[6]), 'h1234);
    frame(1, OP_WR_ADDR, 64'h05, 8);
    frame(1, OP_WR_DATA, 64'hBEEFCAFE, 32);
    chk("d1_mem5", int'(dut1.RAM.MEM[5]), 'hBEEF);
    chk("d1_mem6_kept", int'(dut1.RAM.MEM[6]), 'h1234);
    chk("d1_wr_addr", int'(dut1.wr_addr_q), 6);
    frame(1, OP_WR_ADDR, 64'd199, 8);
    frame(1, OP_WR_DATA, 64'h0199, 16);
    chk("d1_mem199", int'(dut1.RAM.MEM[199]), 'h0199);
    chk("d1_wr_wrap", int'(dut1.wr_addr_q), 0);
    frame(1, OP_WR_DATA, 64'hA000, 16);
    chk("d1_mem0", int'(dut1.RAM.MEM[0]), 'hA000);
    frame(1, OP_RD_ADDR, 64'd199, 8);
    rd_frame(1, 16, 1, 1'b0, 16'h0199, 16'h0, 16'h0);
    chk("d1_rd_wrap", int'(dut1.rd_addr_q), 0);
    rd_frame(1, 16, 1, 1'b0, 16'hA000, 16'h0, 16'h0);
    chk("d1_rd_next", int'(dut1.rd_addr_q), 1);
    frame(1, OP_RD_ADDR, 64'hF0, 8);
    chk("d1_rd_raw", int'(dut1.rd_addr_q), 'hF0);
    rd_frame(1, 16, 1, 1'b0, 16'hA000, 16'h0, 16'h0);
    chk("d1_rd_clamp", int'(dut1.rd_addr_q), 1);

    // Reset in the middle of a read
    frame(0, OP_RD_ADDR, 64'h7E, 8);
    p = cyc + 1;
    push_exp(0, p + 3, 1'b0, "mid_pre");
    for (int i = 7; i >= 3; i--) push_exp(0, p + 4 + (7 - i), 1'(8'hA5 >> i), "mid_bit");
    set_pins(0, 1'b0, 1'b0);
    @(negedge clk); set_pins(0, 1'b0, 1'b1);
    @(negedge clk); set_pins(0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); set_pins(0, 1'b0, 1'b0);
    end
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("rst_mid_miso", int'(miso0), 0);
    chk("rst_mid_state", int'(dut0.state_q), int'(IDLE));
    chk("rst_mid_rd_addr", int'(dut0.rd_addr_q), 0);
    @(negedge clk);
    rstn = 1'b1;
    set_pins(0, 1'b1, 1'b0);
    @(negedge clk);
    chk("rst_mem_7e", int'(dut0.RAM.MEM[8'h7E]), 'hA5);
    chk("rst_mem_fe", int'(dut0.RAM.MEM[8'hFE]), 'h11);

    repeat (5) @(negedge clk);
    while (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      checks++;
      failures++;
      $display("FAIL %s dut%0d: expectation for cyc %0d never checked (now %0d)",
               e.tag, e.dut, e.cyc, cyc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
